// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game sequencer: owns IDLE/CLEAR/PLAY/PAUSE/OVER/WON, drives game_logic reset and the update tick.
// All outputs registered; update_tick follows its frame_start by one cycle. Optional pause via GAME_PAUSE_EN.
module game_flow_ctrl #(
    parameter int TAIL_W       = 8,
    parameter int BASE_PERIOD  = 8,
    parameter int MIN_PERIOD   = 2,
    parameter int SCORE_STEP   = 4,
    parameter int CLEAR_FRAMES = 2,
    parameter int END_HOLD     = 120
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              start_btn,
    input  logic              game_over,
    input  logic              game_won,
    input  logic [TAIL_W-1:0] tail_count,
    output logic              logic_reset,
    output logic              update_tick,
    output logic [2:0]        game_state,
    output logic              blink,
    output logic [3:0]        period
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4,
        S_WON   = 3'd5
    } state_t;

    localparam int FCW = $clog2(CLEAR_FRAMES + 16);
    localparam int HW  = $clog2(END_HOLD + 2);

    state_t             state_q, state_d;
    logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [3:0]         blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [3:0]         period_q, period_d;
    logic               tick_q, tick_d;
    logic               logic_reset_q, logic_reset_d;
    logic               start_prev_q;
    logic               start_rise;
    logic [TAIL_W-1:0]  red;
    logic [3:0]         period_calc;
    logic [FCW-1:0]     clear_cnt_next;

    assign start_rise = start_btn & ~start_prev_q;

    // Saturating period: never drops below MIN_PERIOD, never wraps for large scores.
    always_comb begin
        red = tail_count / TAIL_W'(SCORE_STEP);
        if (red >= TAIL_W'(BASE_PERIOD - MIN_PERIOD)) begin
            period_calc = 4'(MIN_PERIOD);
        end else begin
            period_calc = 4'(BASE_PERIOD) - red[3:0];
        end
    end

    assign clear_cnt_next = frame_cnt_q + FCW'(frame_start);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        period_d    = period_q;
        tick_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                blink_d = 1'b0;
                if (start_rise) begin
                    state_d     = S_CLEAR;
                    hold_d      = '0;
                    frame_cnt_d = FCW'(frame_start);
                end
            end
            S_CLEAR: begin
                blink_d = 1'b0;
                if (clear_cnt_next >= FCW'(CLEAR_FRAMES)) begin
                    state_d     = S_PLAY;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = clear_cnt_next;
                end
            end
            S_PLAY: begin
                blink_d = 1'b0;
                // Exits take priority; a frame_start in the same cycle is dropped, so its tick never fires.
                if (game_over) begin
                    state_d     = S_OVER;
                    hold_d      = '0;
                    blink_cnt_d = '0;
                end else if (game_won) begin
                    state_d     = S_WON;
                    hold_d      = '0;
                    blink_cnt_d = '0;
`ifdef GAME_PAUSE_EN
                end else if (start_rise) begin
                    state_d     = S_PAUSE;
                    blink_cnt_d = '0;
`endif
                end else if (frame_start) begin
                    if (frame_cnt_q == FCW'(period_q - 4'd1)) begin
                        tick_d      = 1'b1;
                        frame_cnt_d = '0;
                        period_d    = period_calc;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (start_rise) begin
                    state_d = S_PLAY;
                    blink_d = 1'b0;
                end else if (frame_start) begin
                    blink_cnt_d = blink_cnt_q + 4'd1;
                    if (blink_cnt_q == 4'hF) begin
                        blink_d = ~blink_q;
                    end
                end
            end
`endif
            S_OVER, S_WON: begin
                if (start_rise && (hold_q == HW'(END_HOLD))) begin
                    state_d     = S_CLEAR;
                    hold_d      = '0;
                    blink_d     = 1'b0;
                    frame_cnt_d = FCW'(frame_start);
                end else if (frame_start) begin
                    if (hold_q != HW'(END_HOLD)) begin
                        hold_d = hold_q + HW'(1);
                    end
                    blink_cnt_d = blink_cnt_q + 4'd1;
                    if (blink_cnt_q == 4'hF) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                blink_d = 1'b0;
            end
        endcase

        logic_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= '0;
            hold_q        <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            period_q      <= 4'(BASE_PERIOD);
            tick_q        <= 1'b0;
            logic_reset_q <= 1'b1;
            start_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            hold_q        <= hold_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            period_q      <= period_d;
            tick_q        <= tick_d;
            logic_reset_q <= logic_reset_d;
            start_prev_q  <= start_btn;
        end
    end

    assign logic_reset = logic_reset_q;
    assign update_tick = tick_q;
    assign game_state  = state_q;
    assign blink       = blink_q;
    assign period      = period_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a queue of expected tick values per frame.
module tb_game_flow_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       start_btn;
    logic       game_over;
    logic       game_won;
    logic [7:0] tail_count;
    logic       logic_reset;
    logic       update_tick;
    logic [2:0] game_state;
    logic       blink;
    logic [3:0] period;

    int errors = 0;
    int checks = 0;
    int ticks  = 0;
    int m_cnt;
    int m_period;
    bit exp_q[$];

    game_flow_ctrl dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .game_over   (game_over),
        .game_won    (game_won),
        .tail_count  (tail_count),
        .logic_reset (logic_reset),
        .update_tick (update_tick),
        .game_state  (game_state),
        .blink       (blink),
        .period      (period)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int calc_period(input int tail);
        int p;
        p = 8 - tail / 4;
        if (p < 2) p = 2;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge three cycles later.
    task automatic do_frame(input bit exp_tick);
        bit e;
        exp_q.push_back(exp_tick);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        e = exp_q.pop_front();
        chk("tick", {31'd0, update_tick}, {31'd0, e});
        if (update_tick === 1'b1) ticks++;
        @(negedge vga_clk);
        chk("tick_width", {31'd0, update_tick}, 32'd0);
        @(negedge vga_clk);
    endtask

    task automatic play_frame();
        bit e;
        e = (m_cnt == m_period - 1);
        do_frame(e);
        if (e) begin
            m_cnt    = 0;
            m_period = calc_period(int'(tail_count));
        end else begin
            m_cnt++;
        end
    endtask

    task automatic press();
        start_btn = 1'b1;
        @(negedge vga_clk);
        start_btn = 1'b0;
        @(negedge vga_clk);
    endtask

    initial begin
        int t0;
        reset       = 1'b1;
        frame_start = 1'b0;
        start_btn   = 1'b1;
        game_over   = 1'b0;
        game_won    = 1'b0;
        tail_count  = 8'd0;
        repeat (3) @(negedge vga_clk);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_lreset", 32'(logic_reset), 32'd1);
        chk("rst_tick", 32'(update_tick), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_period", 32'(period), 32'd8);

        // Button held through reset must not start a game.
        reset = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk("held_btn_idle", 32'(game_state), 32'd0);
        start_btn = 1'b0;
        do_frame(1'b0);
        chk("idle_state", 32'(game_state), 32'd0);

        press();
        chk("clear_state", 32'(game_state), 32'd1);
        chk("clear_lreset", 32'(logic_reset), 32'd1);
        do_frame(1'b0);
        chk("clear_f1_state", 32'(game_state), 32'd1);
        chk("clear_f1_lreset", 32'(logic_reset), 32'd1);
        do_frame(1'b0);
        chk("play_state", 32'(game_state), 32'd2);
        chk("play_lreset", 32'(logic_reset), 32'd0);

        // 40 frames at score 0: five ticks, period stays 8.
        m_cnt = 0;
        m_period = 8;
        ticks = 0;
        for (int i = 0; i < 40; i++) play_frame();
        chk("ticks_40", 32'(ticks), 32'd5);
        chk("period_8", 32'(period), 32'd8);

        tail_count = 8'd12;
        for (int i = 0; i < 8; i++) play_frame();
        chk("period_5", 32'(period), 32'd5);
        tail_count = 8'd200;
        for (int i = 0; i < 5; i++) play_frame();
        chk("period_sat", 32'(period), 32'd2);
        t0 = ticks;
        for (int i = 0; i < 4; i++) play_frame();
        chk("ticks_p2", 32'(ticks - t0), 32'd2);
        play_frame();

        // Tick due in the same cycle game_over and game_won rise.
        exp_q.push_back(1'b0);
        frame_start = 1'b1;
        game_over   = 1'b1;
        game_won    = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        chk("over_tick", {31'd0, update_tick}, {31'd0, exp_q.pop_front()});
        chk("over_state", 32'(game_state), 32'd4);
        chk("over_lreset", 32'(logic_reset), 32'd0);
        chk("over_period", 32'(period), 32'd2);
        @(negedge vga_clk);
        game_over = 1'b0;
        game_won  = 1'b0;

        for (int f = 1; f <= 121; f++) begin
            do_frame(1'b0);
            if (f == 15) chk("blink_f15", 32'(blink), 32'd0);
            if (f == 16) chk("blink_f16", 32'(blink), 32'd1);
            if (f == 32) chk("blink_f32", 32'(blink), 32'd0);
            if (f == 50 || f == 119) begin
                press();
                chk("hold_ignore", 32'(game_state), 32'd4);
            end
        end
        chk("blink_f121", 32'(blink), 32'd1);
        press();
        chk("restart_state", 32'(game_state), 32'd1);
        chk("restart_blink", 32'(blink), 32'd0);
        chk("restart_lreset", 32'(logic_reset), 32'd1);
        do_frame(1'b0);
        do_frame(1'b0);
        chk("replay_state", 32'(game_state), 32'd2);

        // Reset pulse coincident with the frame_start that would tick.
        tail_count = 8'd0;
        m_cnt = 0;
        m_period = 2;
        play_frame();
        frame_start = 1'b1;
        reset       = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        reset       = 1'b0;
        chk("mid_rst_tick", 32'(update_tick), 32'd0);
        chk("mid_rst_state", 32'(game_state), 32'd0);
        chk("mid_rst_lreset", 32'(logic_reset), 32'd1);
        chk("mid_rst_period", 32'(period), 32'd8);
        chk("mid_rst_blink", 32'(blink), 32'd0);
        @(negedge vga_clk);
        chk("mid_rst_tick2", 32'(update_tick), 32'd0);
        do_frame(1'b0);

        press();
        do_frame(1'b0);
        do_frame(1'b0);
        chk("play2_state", 32'(game_state), 32'd2);
        m_cnt = 0;
        m_period = 8;
        for (int i = 0; i < 3; i++) play_frame();
        press();
`ifdef GAME_PAUSE_EN
        chk("pause_state", 32'(game_state), 32'd3);
        for (int f = 1; f <= 100; f++) begin
            do_frame(1'b0);
            if (f == 16) chk("pause_blink16", 32'(blink), 32'd1);
            if (f == 32) chk("pause_blink32", 32'(blink), 32'd0);
        end
        game_over = 1'b1;
        @(negedge vga_clk);
        game_over = 1'b0;
        chk("pause_ignore_over", 32'(game_state), 32'd3);
        press();
        chk("resume_state", 32'(game_state), 32'd2);
        chk("resume_blink", 32'(blink), 32'd0);
        t0 = ticks;
        for (int i = 0; i < 4; i++) play_frame();
        chk("resume_no_tick", 32'(ticks - t0), 32'd0);
        play_frame();
        chk("resume_tick", 32'(ticks - t0), 32'd1);
`else
        chk("nopause_state", 32'(game_state), 32'd2);
        t0 = ticks;
        for (int i = 0; i < 10; i++) play_frame();
        chk("nopause_ticks", 32'(ticks - t0), 32'd1);
        chk("nopause_state2", 32'(game_state), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
